// File: rtl/vending_pkg.sv
// +------------------------------------------------------------------+
// | vending_pkg                                                      |
// | Coin codes, coin-to-unit decode and FSM state encoding.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PAYOUT  = 1'b1
  } state_t;

  function automatic logic [2:0] coin_units(input logic [1:0] code);
    logic [2:0] units;
    case (code)
      COIN_5:  units = 3'd1;
      COIN_10: units = 3'd2;
      COIN_25: units = 3'd5;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

`default_nettype wire

// File: rtl/change_payout.sv
// +------------------------------------------------------------------+
// | change_payout                                                    |
// | Down-counter emitting one registered chg5 pulse per loaded unit. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module change_payout
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  output logic                chg5,
  output logic                busy,
  output logic                last
);

  localparam logic [CREDIT_W-1:0] c_one = {{(CREDIT_W-1){1'b0}}, 1'b1};

  logic [CREDIT_W-1:0] r_count;
  logic                r_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (load && (load_val != '0)) begin
      r_count  <= load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_count <= r_count - c_one;
      if (r_count == c_one) begin
        r_active <= 1'b0;
      end
    end
  end

  assign chg5 = r_active;
  assign busy = r_active;
  assign last = r_active && (r_count == c_one);

endmodule

`default_nettype wire

// File: rtl/vending_mealy_param.sv
// +------------------------------------------------------------------+
// | vending_mealy_param                                              |
// | Parametrised coin vending controller with change and refund.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module vending_mealy_param
  import vending_pkg::*;
#(
  parameter int PRICE_UNITS = 4,
  parameter int CREDIT_W    = 4,
  parameter int REG_OUT     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic                chg5,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W:0]   c_price_ext = PRICE_UNITS[CREDIT_W:0];
  localparam logic [CREDIT_W-1:0] c_price     = PRICE_UNITS[CREDIT_W-1:0];

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;

  logic [2:0]          w_units;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_rem;
  logic [CREDIT_W-1:0] w_load_val;
  logic                w_collect;
  logic                w_has_coin;
  logic                w_vend;
  logic                w_refund;
  logic                w_load;
  logic                w_last;

  assign w_units    = coin_units(coin);
  assign w_sum      = {1'b0, r_credit} + {{(CREDIT_W-2){1'b0}}, w_units};
  // Only consumed when vending, where sum >= price so the narrow subtract is exact.
  assign w_rem      = w_sum[CREDIT_W-1:0] - c_price;
  assign w_collect  = (r_state == ST_COLLECT);
  assign w_has_coin = (coin != COIN_NONE);
  assign w_vend     = w_collect && !cancel && w_has_coin && (w_sum >= c_price_ext);
  assign w_refund   = w_collect && cancel && (w_sum != '0);
  assign w_load     = w_refund || (w_vend && (w_rem != '0));
  assign w_load_val = cancel ? w_sum[CREDIT_W-1:0] : w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_COLLECT;
      r_credit <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_refund) begin
            r_credit <= '0;
            r_state  <= ST_PAYOUT;
          end else if (w_vend) begin
            r_credit <= '0;
            if (w_rem != '0) begin
              r_state <= ST_PAYOUT;
            end
          end else if (!cancel && w_has_coin) begin
            r_credit <= w_sum[CREDIT_W-1:0];
          end
        end
        ST_PAYOUT: begin
          if (w_last) begin
            r_state <= ST_COLLECT;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  change_payout #(
    .CREDIT_W (CREDIT_W)
  ) u_payout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .chg5     (chg5),
    .busy     (busy),
    .last     (w_last)
  );

  assign coin_rej = !w_collect && w_has_coin;
  assign credit   = r_credit;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic r_dispense;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dispense <= 1'b0;
        end else begin
          r_dispense <= w_vend;
        end
      end
      assign dispense = r_dispense;
    end else begin : g_mealy_out
      // Gated so a coin arriving while reset is held cannot vend.
      assign dispense = rst_n && w_vend;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vending_mealy_param.sv
// +------------------------------------------------------------------+
// | tb_vending_mealy_param                                           |
// | Directed self-checking bench for vending_mealy_param.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_vending_mealy_param;

  localparam logic [1:0] C0  = 2'b00;
  localparam logic [1:0] C5  = 2'b01;
  localparam logic [1:0] C10 = 2'b10;
  localparam logic [1:0] C25 = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] coin_a = 2'b00;
  logic       cancel_a = 1'b0;
  logic [1:0] coin_b = 2'b00;

  logic       disp0, chg0, rej0, busy0;
  logic [3:0] cred0;
  logic       disp1, chg1, rej1, busy1;
  logic [3:0] cred1;
  logic       disp2, chg2, rej2, busy2;
  logic [3:0] cred2;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  vending_mealy_param #(.PRICE_UNITS(4), .CREDIT_W(4), .REG_OUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .coin(coin_a), .cancel(cancel_a),
    .dispense(disp0), .chg5(chg0), .coin_rej(rej0), .busy(busy0), .credit(cred0)
  );

  vending_mealy_param #(.PRICE_UNITS(5), .CREDIT_W(4), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .coin(coin_b), .cancel(1'b0),
    .dispense(disp1), .chg5(chg1), .coin_rej(rej1), .busy(busy1), .credit(cred1)
  );

  vending_mealy_param #(.PRICE_UNITS(5), .CREDIT_W(4), .REG_OUT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .coin(coin_b), .cancel(1'b0),
    .dispense(disp2), .chg5(chg2), .coin_rej(rej2), .busy(busy2), .credit(cred2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [1:0] ca, input logic xa, input logic [1:0] cb);
    @(negedge clk);
    coin_a   = ca;
    cancel_a = xa;
    coin_b   = cb;
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_credit", 32'(cred0), 0);
    check("rst_disp",   32'(disp0), 0);
    check("rst_chg5",   32'(chg0),  0);
    check("rst_busy",   32'(busy0), 0);
    check("rst_rej",    32'(rej0),  0);
    check("rst_disp_reg", 32'(disp1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Exact price: 10 + 10
    drive(C10, 1'b0, C0);
    check("s1_disp_first", 32'(disp0), 0);
    drive(C10, 1'b0, C0);
    check("s1_cred_2", 32'(cred0), 2);
    check("s1_disp", 32'(disp0), 1);
    drive(C0, 1'b0, C0);
    check("s1_cred_0", 32'(cred0), 0);
    check("s1_no_chg", 32'(chg0), 0);
    check("s1_disp_low", 32'(disp0), 0);

    // 5, 10, 10 -> one change pulse
    drive(C5, 1'b0, C0);
    check("s2_cred_0", 32'(cred0), 0);
    drive(C10, 1'b0, C0);
    check("s2_cred_1", 32'(cred0), 1);
    check("s2_no_disp", 32'(disp0), 0);
    drive(C10, 1'b0, C0);
    check("s2_cred_3", 32'(cred0), 3);
    check("s2_disp", 32'(disp0), 1);
    drive(C0, 1'b0, C0);
    check("s2_chg", 32'(chg0), 1);
    check("s2_busy", 32'(busy0), 1);
    check("s2_cred_clr", 32'(cred0), 0);
    drive(C0, 1'b0, C0);
    check("s2_chg_end", 32'(chg0), 0);
    check("s2_busy_end", 32'(busy0), 0);

    // Max overpay: 10, 5, 25 -> 4 pulses, coin rejected during payout
    drive(C10, 1'b0, C0);
    drive(C5, 1'b0, C0);
    check("s3_cred_2", 32'(cred0), 2);
    drive(C25, 1'b0, C0);
    check("s3_cred_3", 32'(cred0), 3);
    check("s3_disp", 32'(disp0), 1);
    drive(C5, 1'b0, C0);
    check("s3_rej", 32'(rej0), 1);
    check("s3_chg_p1", 32'(chg0), 1);
    for (int i = 0; i < 5; i++) begin
      drive(C0, 1'b0, C0);
      check($sformatf("s3_chg_p%0d", i + 2), 32'(chg0), 32'(i < 3));
      check("s3_rej_clr", 32'(rej0), 0);
      check("s3_disp_payout", 32'(disp0), 0);
    end
    check("s3_cred_after", 32'(cred0), 0);

    // Cancel with same-cycle coin: 10 then cancel+5 -> 3 pulses
    drive(C10, 1'b0, C0);
    drive(C5, 1'b1, C0);
    check("s4_no_disp", 32'(disp0), 0);
    check("s4_cred_2", 32'(cred0), 2);
    for (int i = 0; i < 5; i++) begin
      drive(C0, 1'b0, C0);
      check($sformatf("s4_chg_%0d", i), 32'(chg0), 32'(i < 3));
      check("s4_cred_0", 32'(cred0), 0);
    end
    drive(C0, 1'b1, C0);
    drive(C0, 1'b0, C0);
    check("s4_idle_cancel_chg", 32'(chg0), 0);
    check("s4_idle_cancel_busy", 32'(busy0), 0);

    // Cancel overrides a vend in the same cycle: 10 then cancel+10 -> 4 pulses
    drive(C10, 1'b0, C0);
    drive(C10, 1'b1, C0);
    check("s4b_no_disp", 32'(disp0), 0);
    for (int i = 0; i < 6; i++) begin
      drive(C0, 1'b0, C0);
      check($sformatf("s4b_chg_%0d", i), 32'(chg0), 32'(i < 4));
    end

    // Registered vs Mealy dispense at PRICE_UNITS=5
    drive(C0, 1'b0, C25);
    check("s5_mealy_disp", 32'(disp2), 1);
    check("s5_reg_disp_early", 32'(disp1), 0);
    drive(C0, 1'b0, C0);
    check("s5_reg_disp", 32'(disp1), 1);
    check("s5_mealy_disp_late", 32'(disp2), 0);
    check("s5_reg_no_chg", 32'(chg1), 0);
    drive(C0, 1'b0, C0);
    check("s5_reg_disp_off", 32'(disp1), 0);
    check("s5_mealy_no_chg", 32'(chg2), 0);

    // Async reset mid-payout
    drive(C10, 1'b0, C0);
    drive(C5, 1'b0, C0);
    drive(C25, 1'b0, C0);
    check("s6_disp", 32'(disp0), 1);
    drive(C0, 1'b0, C0);
    check("s6_chg_p1", 32'(chg0), 1);
    drive(C0, 1'b0, C0);
    check("s6_chg_p2", 32'(chg0), 1);
    drive(C0, 1'b0, C0);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_chg", 32'(chg0), 0);
    check("s6_rst_busy", 32'(busy0), 0);
    check("s6_rst_disp", 32'(disp0), 0);
    check("s6_rst_cred", 32'(cred0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(C0, 1'b0, C0);
      check($sformatf("s6_post_chg_%0d", i), 32'(chg0), 0);
    end
    drive(C10, 1'b0, C0);
    drive(C0, 1'b0, C0);
    check("s6_post_cred", 32'(cred0), 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
